addsub_nbit_serial: RTL
=======================

# addsub_nbit_serial

Multi-cycle, digit-serial integer adder/subtractor generalising the fixed-width combinational subtractor to any WIDTH, a configurable digit size per cycle, and a runtime add/sub mode with carry/borrow and signed-overflow flags. One operand pair is processed DIGIT bits per cycle, LSB digit first, behind a valid/ready handshake on both sides. It serves as the sequential arithmetic benchmark for bit/digit-serial PIM datapaths, where wide carry chains are not available in one step.

## Interface
- WIDTH, 64, operand/result width in bits; must satisfy WIDTH % DIGIT == 0 (elaboration error otherwise)
- DIGIT, 8, bits processed per RUN cycle; 1 ≤ DIGIT ≤ WIDTH; NDIG = WIDTH/DIGIT
- IMPL_TYPE, 0, passed to the digit datapath sub-module to select its gate-level implementation
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  operands and op valid
- in_ready  output  1  block can accept an operation
- op  input  1  0 = A+B, 1 = A−B
- A  input  WIDTH  first operand
- B  input  WIDTH  second operand
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- Result  output  WIDTH  A+B or A−B, mod 2^WIDTH
- Cout  output  1  add: unsigned carry-out; sub: unsigned borrow (1 iff A < B unsigned)
- Ovf  output  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch A, B (B inverted if op=1), op; carry register ← op; digit counter ← 0; Result register ← 0; → RUN.
- RUN: in_ready=0. Each cycle: digit k = counter; sum = A[k] + B'[k] + carry; write sum[DIGIT-1:0] to Result digit k; carry ← sum[DIGIT]; counter ← counter+1. On the cycle processing k = NDIG−1: compute flags, → DONE.
- Flags at last digit: Cout = carry_out XOR op; Ovf = (sign(A) == sign(B')) && (sign(Result) != sign(A)), with B' the possibly inverted operand.
- DONE: out_valid=1; Result, Cout, Ovf held stable. On out_ready → IDLE (out_valid drops next cycle).
- in_valid while not in IDLE is ignored; no queueing.
- op and operand changes after acceptance have no effect.
- Counter width: $clog2(NDIG), minimum 1 bit; no wrap beyond NDIG−1.

## Timing
- Reset values: in_ready=1, out_valid=0, Result=0, Cout=0, Ovf=0, state IDLE, counter 0, carry 0.
- rst asserted in any state (including mid-RUN, DONE with out_ready low) wins over all other events; next cycle equals reset values; partial result discarded.
- Latency: accept on edge t → out_valid=1 after edge t+NDIG (NDIG RUN cycles). WIDTH=64, DIGIT=8: 8 cycles; DIGIT=WIDTH: 1 cycle.
- Minimum initiation interval: NDIG+2 cycles (accept, NDIG RUN, DONE handshake, IDLE re-accept).
- in_ready is a pure function of state (no combinational path from out_ready or in_valid).
- out_valid held until out_ready; Result must not change while out_valid=1.

## Structure
- Sub-module addsub_digit: combinational DIGIT-bit adder with carry-in/carry-out, IMPL_TYPE selects ripple vs. gate-level variant; instantiated once.
- Shared package: state enum (IDLE/RUN/DONE), op encoding constants (OP_ADD=0, OP_SUB=1).
- Top: FSM, operand/result shift or indexed registers, digit counter, carry register, flag logic.

## Test plan
- WIDTH=64, DIGIT=8, sub 5−3 → Result=2, Cout=0, Ovf=0, out_valid exactly 8 cycles after accept edge.
- Sub 0−1 → Result=0xFFFF_FFFF_FFFF_FFFF, Cout=1, Ovf=0; sub 0x8000_0000_0000_0000−1 → 0x7FFF_FFFF_FFFF_FFFF, Cout=0, Ovf=1.
- Add 0xFFFF_FFFF_FFFF_FFFF+1 → 0, Cout=1, Ovf=0; add 0x7FFF_FFFF_FFFF_FFFF+1 → 0x8000_0000_0000_0000, Cout=0, Ovf=1.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 → Result/flags stable, in_ready=0, new operation not accepted until after out_ready handshake.
- rst pulsed at RUN digit 3 → next cycle in_ready=1, out_valid=0, Result=0; subsequent 10−4 completes correctly (6).
- Parameter sweep DIGIT ∈ {1, 8, 64}, 1000 random ops each vs. reference model → exact Result/Cout/Ovf match, latency = NDIG.

Source files
------------

// File: rtl/addsub_nbit_serial_pkg.sv
// Shared constants for the digit-serial adder/subtractor: FSM state codes,
// op encodings and the registered flag bundle.
package addsub_nbit_serial_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/addsub_nbit_serial_if.sv
// Operand/result handshake bundle for addsub_nbit_serial.
// The master drives operands and consumes results; the slave is the block.
interface addsub_nbit_serial_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, Result, Cout, Ovf
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, Result, Cout, Ovf
    );
endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit adder with carry in/out. IMPL_TYPE 0 is a
// behavioural ripple sum, any other value an explicit full-adder chain.
module addsub_digit #(
    parameter int DIGIT     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    if (IMPL_TYPE == 0) begin : g_ripple
        logic [DIGIT:0] sum_w;
        assign sum_w = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
        assign s     = sum_w[DIGIT-1:0];
        assign cout  = sum_w[DIGIT];
    end else begin : g_gates
        logic [DIGIT-1:0] s_g;
        logic             c_g;
        // carry propagates through a chain of generate/propagate full adders
        always_comb begin
            s_g = '0;
            c_g = cin;
            for (int i = 0; i < DIGIT; i++) begin
                s_g[i] = a[i] ^ b[i] ^ c_g;
                c_g    = (a[i] & b[i]) | (c_g & (a[i] ^ b[i]));
            end
        end
        assign s    = s_g;
        assign cout = c_g;
    end

endmodule

// File: rtl/addsub_nbit_serial.sv
// Digit-serial WIDTH-bit add/sub: DIGIT bits per cycle, LSB digit first,
// with carry/borrow and signed-overflow flags behind valid/ready handshakes.
module addsub_nbit_serial
    import addsub_nbit_serial_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DIGIT     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    addsub_nbit_serial_if.slave   bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0 || DIGIT > WIDTH) begin : g_param_check
        $error("addsub_nbit_serial: WIDTH must be a non-zero multiple of DIGIT");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    flags_t           flags;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             op_q;
    logic             a_msb;
    logic             b_msb;

    logic [DIGIT-1:0] sum_d;
    logic             carry_nx;
    logic             accept;
    logic             last;

    // Overflow when both addends share a sign that the result does not.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (state == RUN) && (cnt == LAST);

    addsub_digit #(
        .DIGIT     (DIGIT),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .cin  (carry),
        .s    (sum_d),
        .cout (carry_nx)
    );

    always_comb begin
        res_nx = res;
        for (int g = 0; g < NDIG; g++) begin
            if (cnt == CW'(g)) res_nx[g*DIGIT +: DIGIT] = sum_d;
        end
    end

    // control, result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            res   <= '0;
            flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state <= RUN;
                        cnt   <= '0;
                        carry <= (bus.op == OP_SUB);
                        res   <= '0;
                    end
                end
                RUN: begin
                    res   <= res_nx;
                    carry <= carry_nx;
                    if (last) begin
                        state      <= DONE;
                        flags.cout <= carry_nx ^ op_q;
                        flags.ovf  <= signed_ovf(a_msb, b_msb, sum_d[DIGIT-1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // operand shift registers; the low digit feeds the adder each RUN cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh  <= bus.A;
            b_sh  <= (bus.op == OP_SUB) ? ~bus.B : bus.B;
            op_q  <= bus.op;
            a_msb <= bus.A[WIDTH-1];
            b_msb <= (bus.op == OP_SUB) ? ~bus.B[WIDTH-1] : bus.B[WIDTH-1];
        end else if (state == RUN) begin
            a_sh <= a_sh >> DIGIT;
            b_sh <= b_sh >> DIGIT;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.Result    = res;
    assign bus.Cout      = flags.cout;
    assign bus.Ovf       = flags.ovf;

endmodule
